// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: bit stuffing, NRZI encoding and EOP generation onto dp/dm.
// Optional macro USB_TX_SYNC_GEN_EN makes the block emit SYNC itself before the upstream data.
module usb_tx_line_encoder #(
    parameter int STUFF_LEN   = 6,
    parameter int EOP_SE0_LEN = 2,
    parameter int EOP_J_LEN   = 1
) (
    input  logic clk,
    input  logic rst_b,
    input  logic bit_in,
    input  logic bit_in_avail,
    output logic in_stall,
    output logic dp,
    output logic dm,
    output logic out_en,
    output logic tx_busy,
    output logic eop_done
);

    localparam int CNT_W   = $clog2(STUFF_LEN + 1);
    localparam int EOP_MAX = (EOP_SE0_LEN > EOP_J_LEN) ? EOP_SE0_LEN : EOP_J_LEN;
    localparam int EOP_W   = $clog2(EOP_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        STUFF,
        EOP_SE0,
        EOP_J
`ifdef USB_TX_SYNC_GEN_EN
        , SYNC
`endif
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_ones_cnt, w_ones_nxt, w_ones_inc;
    logic [EOP_W-1:0]   r_eop_cnt, w_eop_cnt_nxt;
    logic               r_level, w_level_nxt;
    logic               r_dp, w_dp_nxt;
    logic               r_dm, w_dm_nxt;
    logic               r_out_en, w_out_en_nxt;
    logic               r_tx_busy, w_tx_busy_nxt;
    logic               r_eop_done, w_eop_done_nxt;
    logic               w_emit, w_tx_bit, w_stuff_due, w_lvl;
`ifdef USB_TX_SYNC_GEN_EN
    logic [2:0]         r_sync_cnt, w_sync_cnt_nxt;
`endif

    assign w_ones_inc  = r_ones_cnt + CNT_W'(1);
    assign w_stuff_due = (w_ones_inc == CNT_W'(STUFF_LEN));

    // r_level is the NRZI line state, 1 = J; every emitted bit updates it and the pins together.
    always_comb begin
        w_state_nxt    = r_state;
        w_ones_nxt     = r_ones_cnt;
        w_eop_cnt_nxt  = r_eop_cnt;
        w_level_nxt    = r_level;
        w_dp_nxt       = r_dp;
        w_dm_nxt       = r_dm;
        w_out_en_nxt   = r_out_en;
        w_tx_busy_nxt  = r_tx_busy;
        w_eop_done_nxt = 1'b0;
        w_emit         = 1'b0;
        w_tx_bit       = bit_in;
        w_lvl          = r_level;
        in_stall       = 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
        w_sync_cnt_nxt = r_sync_cnt;
`endif

        case (r_state)
            IDLE: begin
                if (bit_in_avail) begin
                    w_emit        = 1'b1;
                    w_out_en_nxt  = 1'b1;
                    w_tx_busy_nxt = 1'b1;
`ifdef USB_TX_SYNC_GEN_EN
                    in_stall       = 1'b1;
                    w_tx_bit       = 1'b0;
                    w_sync_cnt_nxt = 3'd1;
                    w_state_nxt    = SYNC;
`else
                    w_state_nxt   = (bit_in && w_stuff_due) ? STUFF : SEND;
`endif
                end
            end
`ifdef USB_TX_SYNC_GEN_EN
            SYNC: begin
                in_stall       = 1'b1;
                w_emit         = 1'b1;
                w_tx_bit       = (r_sync_cnt == 3'd7);
                w_sync_cnt_nxt = r_sync_cnt + 3'd1;
                if (r_sync_cnt == 3'd7) begin
                    w_state_nxt = w_stuff_due ? STUFF : SEND;
                end
            end
`endif
            SEND: begin
                if (bit_in_avail) begin
                    w_emit = 1'b1;
                    if (bit_in && w_stuff_due) begin
                        w_state_nxt = STUFF;
                    end
                end else begin
                    w_dp_nxt      = 1'b0;
                    w_dm_nxt      = 1'b0;
                    w_eop_cnt_nxt = EOP_W'(EOP_SE0_LEN - 1);
                    w_state_nxt   = EOP_SE0;
                end
            end
            STUFF: begin
                in_stall    = 1'b1;
                w_emit      = 1'b1;
                w_tx_bit    = 1'b0;
                w_state_nxt = SEND;
            end
            EOP_SE0: begin
                in_stall = 1'b1;
                if (r_eop_cnt == '0) begin
                    w_dp_nxt      = 1'b1;
                    w_dm_nxt      = 1'b0;
                    w_eop_cnt_nxt = EOP_W'(EOP_J_LEN - 1);
                    w_state_nxt   = EOP_J;
                end else begin
                    w_eop_cnt_nxt = r_eop_cnt - EOP_W'(1);
                end
            end
            EOP_J: begin
                in_stall = 1'b1;
                if (r_eop_cnt == '0) begin
                    w_out_en_nxt   = 1'b0;
                    w_tx_busy_nxt  = 1'b0;
                    w_eop_done_nxt = 1'b1;
                    w_ones_nxt     = '0;
                    w_level_nxt    = 1'b1;
                    w_state_nxt    = IDLE;
                end else begin
                    w_eop_cnt_nxt = r_eop_cnt - EOP_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_emit) begin
            w_lvl       = w_tx_bit ? r_level : ~r_level;
            w_level_nxt = w_lvl;
            w_dp_nxt    = w_lvl;
            w_dm_nxt    = ~w_lvl;
            w_ones_nxt  = w_tx_bit ? w_ones_inc : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state    <= IDLE;
            r_ones_cnt <= '0;
            r_eop_cnt  <= '0;
            r_level    <= 1'b1;
            r_dp       <= 1'b1;
            r_dm       <= 1'b0;
            r_out_en   <= 1'b0;
            r_tx_busy  <= 1'b0;
            r_eop_done <= 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
            r_sync_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ones_cnt <= w_ones_nxt;
            r_eop_cnt  <= w_eop_cnt_nxt;
            r_level    <= w_level_nxt;
            r_dp       <= w_dp_nxt;
            r_dm       <= w_dm_nxt;
            r_out_en   <= w_out_en_nxt;
            r_tx_busy  <= w_tx_busy_nxt;
            r_eop_done <= w_eop_done_nxt;
`ifdef USB_TX_SYNC_GEN_EN
            r_sync_cnt <= w_sync_cnt_nxt;
`endif
        end
    end

    assign dp       = r_dp;
    assign dm       = r_dm;
    assign out_en   = r_out_en;
    assign tx_busy  = r_tx_busy;
    assign eop_done = r_eop_done;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Scoreboard bench for usb_tx_line_encoder: the driver queues hand-computed line symbols,
// and a negedge monitor pops one per driven cycle plus an end marker at each eop_done.
module tb_usb_tx_line_encoder;

    logic clk = 1'b0;
    logic rst_b;
    logic bit_in;
    logic bit_in_avail;
    logic in_stall, dp, dm, out_en, tx_busy, eop_done;

    int errorCount = 0;
    int checkCount = 0;
    logic [3:0] expQ[$];
    bit monOn = 1'b0;

    // Queue entries are {eop_done, tx_busy, dp, dm}.
    localparam logic [3:0] SYM_J   = 4'b0110;
    localparam logic [3:0] SYM_K   = 4'b0101;
    localparam logic [3:0] SYM_SE0 = 4'b0100;
    localparam logic [3:0] SYM_END = 4'b1010;

    usb_tx_line_encoder dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .bit_in       (bit_in),
        .bit_in_avail (bit_in_avail),
        .in_stall     (in_stall),
        .dp           (dp),
        .dm           (dm),
        .out_en       (out_en),
        .tx_busy      (tx_busy),
        .eop_done     (eop_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // J, K, S (SE0) and E (eop_done with bus released) in the order they should appear.
    task automatic expectSeq(input string s);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            case (c)
                "J":     expQ.push_back(SYM_J);
                "K":     expQ.push_back(SYM_K);
                "S":     expQ.push_back(SYM_SE0);
                default: expQ.push_back(SYM_END);
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (monOn && rst_b && (out_en || eop_done)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDrive", {28'd0, eop_done, tx_busy, dp, dm}, 32'hFFFF);
            end else begin
                checkOutput("line", {28'd0, eop_done, tx_busy, dp, dm}, {28'd0, expQ.pop_front()});
            end
        end
    end

    // Bits are sent in string order; each is held until a cycle where in_stall was low.
    task automatic applyStimulus(input string name, input string bits, input int expStalls);
        int stalls = 0;
        bit consumed;
        bit stalled;
        for (int i = 0; i < bits.len(); i++) begin
            bit_in       = (bits[i] == 8'h31);
            bit_in_avail = 1'b1;
            consumed     = 1'b0;
            for (int w = 0; w < 20 && !consumed; w++) begin
                @(negedge clk);
                stalled = in_stall;
                @(posedge clk);
                #1;
                if (stalled) stalls++;
                else consumed = 1'b1;
            end
            if (!consumed) begin
                checkOutput({name, "_consumeTimeout"}, 0, 1);
                break;
            end
        end
        bit_in_avail = 1'b0;
        bit_in       = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, "_stalls"}, stalls, expStalls);
    endtask

    task automatic waitIdle(input string name);
        bit idle = 1'b0;
        for (int w = 0; w < 100 && !idle; w++) begin
            @(posedge clk);
            #2;
            idle = (expQ.size() == 0) && !tx_busy && !out_en && !eop_done;
        end
        if (!idle) checkOutput({name, "_idleTimeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_b        = 1'b1;
        bit_in       = 1'b1;
        bit_in_avail = 1'b1;
        #2 rst_b = 1'b0;
        #1;
        checkOutput("rst_dp", dp, 1);
        checkOutput("rst_dm", dm, 0);
        checkOutput("rst_outEn", out_en, 0);
        checkOutput("rst_txBusy", tx_busy, 0);
        checkOutput("rst_eopDone", eop_done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bit_in_avail = 1'b0;
        bit_in       = 1'b0;
        rst_b        = 1'b1;
        monOn        = 1'b1;
        @(posedge clk);
        #1;

`ifdef USB_TX_SYNC_GEN_EN
        expectSeq("KJKJKJKKKKKKKJKSSJE");
        applyStimulus("syncStuff", "111110", 9);
        waitIdle("syncStuff");
        expectSeq("KJKJKJKKJSSJE");
        applyStimulus("syncZero", "0", 8);
        waitIdle("syncZero");
`else
        expectSeq("KJKJKJKKSSJE");
        applyStimulus("plain", "00000001", 0);
        waitIdle("plain");
        expectSeq("JJJJJJKKKSSJE");
        applyStimulus("stuff", "11111111", 1);
        waitIdle("stuff");
        expectSeq("JJJJJJKSSJE");
        applyStimulus("stuffAtEnd", "111111", 0);
        waitIdle("stuffAtEnd");
        expectSeq("KKSSJE");
        expectSeq("KJSSJE");
        applyStimulus("backA", "01", 0);
        applyStimulus("backB", "00", 3);
        waitIdle("backToBack");
`endif

        // Abort two cycles into a packet: the bus must drop at once with no EOP afterwards.
        expectSeq("KJ");
        bit_in       = 1'b0;
        bit_in_avail = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        #1;
        checkOutput("abort_dp", dp, 1);
        checkOutput("abort_dm", dm, 0);
        checkOutput("abort_outEn", out_en, 0);
        checkOutput("abort_txBusy", tx_busy, 0);
        checkOutput("abort_eopDone", eop_done, 0);
        bit_in_avail = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort_held_outEn", out_en, 0);
        checkOutput("abort_queue", expQ.size(), 0);
        expQ.delete();
        @(negedge clk);
        rst_b = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("postAbort_outEn", out_en, 0);
        checkOutput("postAbort_line", {30'd0, dp, dm}, 2'b10);
        checkOutput("postAbort_eopDone", eop_done, 0);

        checkOutput("queueDrained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
